i2s_audio_tx: RTL and testbench



---
 rtl/i2s_audio_tx.sv | 167 ++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx
// Serialises signed 16-bit stereo samples as Philips-format I2S for the DAC.
// The bit clock is divided down from clk; the half-period constant follows
// ntscmode so the frame rate stays near SAMPLE_RATE on both system clocks.
// A one-deep holding buffer decouples the producer; when no new frame is
// waiting at a frame boundary the previous frame is sent again.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ntscmode          selects the NTSC (1) or PAL (0) divider constant
//   sample_l/_r       two's complement left/right samples
//   sample_valid      producer has a sample pair this cycle
//   sample_ready      holding buffer empty (transfer when valid & ready)
//   underrun          one-cycle pulse: a frame started with the buffer empty
//   i2s_bck           bit clock
//   i2s_ws            word select, 0 = left, 1 = right
//   i2s_din           serial data, MSB first, one bit after ws changes
//
// Build option I2S_AUDIO_TX_UNDERRUN_CNT_EN adds:
//   underrun_clr      synchronous clear of the counter (wins over increment)
//   underrun_cnt      saturating 8-bit count of underrun pulses

module i2s_audio_tx #(
    parameter int unsigned CLK_HZ_PAL  = 31500000,
    parameter int unsigned CLK_HZ_NTSC = 32940000,
    parameter int unsigned SAMPLE_RATE = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ntscmode,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        underrun,
    output logic        i2s_bck,
    output logic        i2s_ws,
    output logic        i2s_din
`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
    ,
    input  logic        underrun_clr,
    output logic [7:0]  underrun_cnt
`endif
);

    localparam int unsigned HALF_PAL  = CLK_HZ_PAL / (SAMPLE_RATE * 64);
    localparam int unsigned HALF_NTSC = CLK_HZ_NTSC / (SAMPLE_RATE * 64);
    localparam logic [15:0] HALF_PAL_M1  = 16'(HALF_PAL - 1);
    localparam logic [15:0] HALF_NTSC_M1 = 16'(HALF_NTSC - 1);

    logic [15:0] div_q, div_d;
    logic        bck_q, bck_d;
    logic        ws_q, ws_d;
    logic        din_q, din_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] last_q, last_d;
    logic [31:0] hold_q, hold_d;
    logic        full_q, full_d;

    logic [15:0] half_m1;
    logic        wrap;
    logic        fall;
    logic        load;
    logic        accept;
    logic [4:0]  bit_nx;

    always_comb begin
        half_m1 = ntscmode ? HALF_NTSC_M1 : HALF_PAL_M1;
        // >= rather than == so that a switch to the shorter constant while the
        // counter is already past it wraps on the next edge instead of running on.
        wrap    = (div_q >= half_m1);
        fall    = wrap && bck_q;
        load    = fall && (bit_cnt_q == 5'd31);
        accept  = sample_valid && !full_q;
        bit_nx  = bit_cnt_q + 5'd1;

        div_d     = wrap ? '0 : div_q + 16'd1;
        bck_d     = wrap ? ~bck_q : bck_q;
        ws_d      = ws_q;
        din_d     = din_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        hold_d    = hold_q;
        full_d    = full_q;

        if (fall) begin
            bit_cnt_d = bit_nx;
            ws_d      = bit_nx[4];
            din_d     = shreg_q[31];
            if (load) begin
                if (full_q) begin
                    shreg_d = hold_q;
                    last_d  = hold_q;
                    full_d  = 1'b0;
                end else begin
                    shreg_d = last_q;
                end
            end else begin
                shreg_d = {shreg_q[30:0], 1'b0};
            end
        end

        // Accept only happens with the buffer empty, so it never collides with
        // the load clearing a full buffer; an accept during an underrun load
        // lands in hold for the following frame.
        if (accept) begin
            hold_d = {sample_l, sample_r};
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            bck_q     <= 1'b0;
            ws_q      <= 1'b0;
            din_q     <= 1'b0;
            bit_cnt_q <= 5'd31;
            shreg_q   <= '0;
            last_q    <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            bck_q     <= bck_d;
            ws_q      <= ws_d;
            din_q     <= din_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
        end
    end

    assign sample_ready = !full_q;
    assign underrun     = load && !full_q;
    assign i2s_bck      = bck_q;
    assign i2s_ws       = ws_q;
    assign i2s_din      = din_q;

`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_clr) begin
            ucnt_d = '0;
        end else if (underrun && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx. A frame-level reference model predicts,
// from elapsed clock count since reset release, when frames start, which
// stereo pair each frame carries and when underrun must pulse. A separate
// I2S receiver decodes the serial stream and compares decoded frames with
// the queued predictions.

module tb_i2s_audio_tx;

    localparam int HP = 31500000 / (24000 * 64);   // PAL half period, 20
    localparam int HN = 32940000 / (24000 * 64);   // NTSC half period, 21

    logic        clk;
    logic        reset;
    logic        ntscmode;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun;
    logic        i2s_bck;
    logic        i2s_ws;
    logic        i2s_din;
`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
    logic        underrun_clr;
    logic [7:0]  underrun_cnt;
`endif

    i2s_audio_tx #(
        .CLK_HZ_PAL (31500000),
        .CLK_HZ_NTSC(32940000),
        .SAMPLE_RATE(24000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ntscmode    (ntscmode),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .underrun    (underrun),
        .i2s_bck     (i2s_bck),
        .i2s_ws      (i2s_ws),
        .i2s_din     (i2s_din)
`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
        ,
        .underrun_clr(underrun_clr),
        .underrun_cnt(underrun_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // posedges since reset release
    int k;
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    bit          sb_on;
    int          H;
    bit          pend_v;
    logic [31:0] pend;
    logic [31:0] last;
    logic [31:0] expq[$];

    // Reference model: frames begin every 64*H clocks, the first at 2*H
    // clocks after release. Evaluated just before the upcoming posedge n.
    always @(negedge clk) begin
        int n;
        bit is_load;
        bit rdy;
        if (reset || !sb_on) begin
            pend_v = 1'b0;
            last   = '0;
            expq.delete();
        end else begin
            n       = k + 1;
            is_load = ((n % (64 * H)) == 2 * H);
            rdy     = !pend_v;
            check1("ready", sample_ready, rdy);
            check1("underrun", underrun, is_load && !pend_v);
            check1("bck", i2s_bck, ((k / H) % 2) == 1);
            if (is_load) begin
                if (pend_v) begin
                    last   = pend;
                    pend_v = 1'b0;
                end
                expq.push_back(last);
            end
            if (sample_valid && rdy) begin
                pend   = {sample_l, sample_r};
                pend_v = 1'b1;
            end
        end
    end

    // I2S receiver: samples ws/din after each bck rising edge.
    int          r;
    bit          pb;
    int          wserr;
    logic [31:0] acc;
    always @(negedge clk) begin
        logic [31:0] f;
        if (reset || !sb_on) begin
            r     = 0;
            pb    = 1'b0;
            wserr = 0;
        end else begin
            if (i2s_bck && !pb) begin
                r++;
                if (r <= 2) begin
                    check1("pre_din", i2s_din, 1'b0);
                    check1("pre_ws", i2s_ws, 1'b0);
                end else begin
                    acc = {acc[30:0], i2s_din};
                    if (i2s_ws !== ((((r - 2) % 32) >= 16) ? 1'b1 : 1'b0)) wserr++;
                    if (((r - 3) % 32) == 31) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL frame_missing actual=%h required=queued_frame", acc);
                        end else begin
                            f = expq.pop_front();
                            if (acc !== f) begin
                                errors++;
                                $display("FAIL frame actual=%h required=%h t=%0t", acc, f, $time);
                            end
                        end
                        checks++;
                        if (wserr != 0) begin
                            errors++;
                            $display("FAIL ws_pattern actual=%0d_bad_bits required=0", wserr);
                        end
                        wserr = 0;
                    end
                end
            end
            pb = i2s_bck;
        end
    end

    task automatic push(input logic [15:0] l, input logic [15:0] rr);
        int n;
        @(posedge clk);
        #1;
        sample_l     = l;
        sample_r     = rr;
        sample_valid = 1'b1;
        n            = 0;
        @(negedge clk);
        while (!sample_ready && n < 3 * 64 * HN) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!sample_ready) begin
            errors++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_l     = 16'($urandom);
        sample_r     = 16'($urandom);
    endtask

    task automatic wait_phase(input int target, input int hh);
        int n = 0;
        @(negedge clk);
        while ((k % (64 * hh)) != target && n < 64 * hh + 4) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Tracks bck phase lengths; optionally changes ntscmode when the divider
    // counter is at sw_cnt (phase length so far = counter + 1).
    task automatic watch(input int ncyc, input int sw_cnt, input logic new_mode,
                         output int maxrun, output int lastper);
        int run  = 0;
        int prev = 0;
        bit pbk  = i2s_bck;
        bit seen = 0;
        bit sw   = 0;
        maxrun  = 0;
        lastper = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i2s_bck == pbk) begin
                run++;
            end else begin
                if (seen && run > maxrun) maxrun = run;
                lastper = prev + run;
                prev    = run;
                run     = 1;
                pbk     = i2s_bck;
                seen    = 1;
            end
            if (seen && !sw && sw_cnt >= 0 && run == sw_cnt + 1) begin
                ntscmode = new_mode;
                sw       = 1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_bck"}, i2s_bck, 1'b0);
        check1({tag, "_ws"}, i2s_ws, 1'b0);
        check1({tag, "_din"}, i2s_din, 1'b0);
        check1({tag, "_underrun"}, underrun, 1'b0);
        check1({tag, "_ready"}, sample_ready, 1'b1);
    endtask

    initial begin
        int maxrun;
        int per;
        reset        = 1'b1;
        ntscmode     = 1'b0;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
        underrun_clr = 1'b0;
`endif
        sb_on = 1'b1;
        H     = HP;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        #3 reset = 1'b0;

        // idle: underrun on every load, all-zero data
        repeat (64 * HP * 3 / 2) @(posedge clk);
        push(16'hA5C3, 16'h3C5A);
        // second pair waits for the buffer to drain
        push(16'h1357, 16'h9BDF);
        push(16'h2468, 16'hACE0);
        push(16'h8001, 16'h7FFF);
        repeat (3 * 64 * HP) @(posedge clk);

        // accept coinciding with a frame load while the buffer is empty
        wait_phase(2 * HP - 2, HP);
        @(posedge clk);
        #1;
        sample_l     = 16'h55AA;
        sample_r     = 16'hC001;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (2 * 64 * HP) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 64 * HP)) @(posedge clk);
            push(16'($urandom), 16'($urandom));
        end

        // reset in bit period 10 with the buffer full
        wait_phase(2 * HP + 1, HP);
        push(16'hBEEF, 16'h0F0F);
        wait_phase(2 * HP + 20 * HP + 5, HP);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        ntscmode = 1'b1;
        H        = HN;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        push(16'h7FFF, 16'h8000);
        push(16'($urandom), 16'($urandom));
        repeat (4 * 64 * HN) @(posedge clk);

        // divider constant changes mid-count
        sb_on = 1'b0;
        @(negedge clk);
        #3 reset = 1'b1;
        ntscmode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        watch(300, -1, 1'b0, maxrun, per);
        checks++;
        if (per != 40) begin
            errors++;
            $display("FAIL bck_period_pal actual=%0d required=40", per);
        end
        watch(400, 19, 1'b1, maxrun, per);
        checks++;
        if (maxrun > 21) begin
            errors++;
            $display("FAIL phase_pal_to_ntsc actual=%0d required<=21", maxrun);
        end
        checks++;
        if (per != 42) begin
            errors++;
            $display("FAIL bck_period_ntsc actual=%0d required=42", per);
        end
        watch(400, 20, 1'b0, maxrun, per);
        checks++;
        if (maxrun > 21) begin
            errors++;
            $display("FAIL phase_ntsc_to_pal actual=%0d required<=21", maxrun);
        end
        checks++;
        if (per != 40) begin
            errors++;
            $display("FAIL bck_period_back_pal actual=%0d required=40", per);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
